// File: rtl/cla_pkg.sv
// cla_pkg: shared types and constants for the sequential carry-lookahead adder.
//   state_t      - controller states (IDLE / RUN / DONE)
//   CLA_WIDTH    - default operand width
//   CLA_GROUP    - default bits resolved per cycle
//   slice_count  - number of GROUP-bit slices in a WIDTH-bit operand
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned CLA_WIDTH = 16;
  localparam int unsigned CLA_GROUP = 4;

  function automatic int unsigned slice_count(input int unsigned width,
                                              input int unsigned group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: combinational GROUP-bit carry-lookahead slice.
// Each bit forms a propagate term p = a|b and an active-low generate term
// g_n = ~(a&b); carries, sum bits and the group propagate/generate pair are
// derived from those per-bit terms.
// Ports:
//   a, b   in  [GROUP-1:0]  operand slices
//   cin    in               carry into bit 0
//   s      out [GROUP-1:0]  sum slice
//   cout   out              carry out of the top bit
//   grp_p  out              group propagate
//   grp_g  out              group generate
module cla_group
  import cla_pkg::*;
#(
  parameter int unsigned GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout,
  output logic             grp_p,
  output logic             grp_g
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g_n;
  logic [GROUP:0]   c;

  assign p   = a | b;
  assign g_n = ~(a & b);

  always_comb begin
    c     = '0;
    c[0]  = cin;
    grp_g = 1'b0;
    for (int unsigned i = 0; i < GROUP; i++) begin
      c[i+1] = ~g_n[i] | (p[i] & c[i]);
      grp_g  = ~g_n[i] | (p[i] & grp_g);
    end
  end

  assign s     = a ^ b ^ c[GROUP-1:0];
  assign cout  = c[GROUP];
  assign grp_p = &p;

endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle carry-lookahead adder, one GROUP-bit slice per
// cycle with a registered inter-slice carry. Operands in and result out over
// valid/ready handshakes. Optional signed-overflow output is enabled by
// defining CLA_OVERFLOW_EN.
// Ports:
//   clk        in                rising-edge clock
//   reset      in                asynchronous active-high reset
//   in_valid   in                operands valid
//   in_ready   out               ready to accept operands (IDLE)
//   a, b       in  [WIDTH-1:0]   operands
//   cin        in                carry-in
//   out_valid  out               result valid (DONE)
//   out_ready  in                consumer accepts result
//   sum        out [WIDTH-1:0]   a+b+cin modulo 2^WIDTH
//   cout       out               carry out of the MSB
//   ovf        out               signed overflow (CLA_OVERFLOW_EN only)
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH,
  parameter int unsigned GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned   N      = slice_count(WIDTH, GROUP);
  localparam int unsigned   KW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_t           state, state_nxt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic [GROUP-1:0] grp_a, grp_b, grp_s;
  logic             grp_cout, grp_p, grp_g;
  logic             carry_nxt;
  logic             last_slice;

  assign grp_a = a_q[k*GROUP +: GROUP];
  assign grp_b = b_q[k*GROUP +: GROUP];

  cla_group #(.GROUP(GROUP)) u_group (
    .a     (grp_a),
    .b     (grp_b),
    .cin   (carry_q),
    .s     (grp_s),
    .cout  (grp_cout),
    .grp_p (grp_p),
    .grp_g (grp_g)
  );

  // Inter-slice carry taken from the group lookahead terms; the slice's own
  // ripple carry must always agree with it.
  assign carry_nxt  = grp_g | (grp_p & carry_q);
  assign last_slice = (k == K_LAST);

  always_comb begin
    assert (grp_cout == carry_nxt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = RUN;
      RUN:     if (last_slice) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

`ifdef CLA_OVERFLOW_EN
  logic ovf_q;
  logic msb_cin;
  // Carry into the MSB recovered from the MSB sum bit and its operand bits.
  assign msb_cin = grp_s[GROUP-1] ^ grp_a[GROUP-1] ^ grp_b[GROUP-1];
  assign ovf     = ovf_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      k       <= '0;
`ifdef CLA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum_q   <= '0;
            k       <= '0;
`ifdef CLA_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
          sum_q[k*GROUP +: GROUP] <= grp_s;
          carry_q                 <= carry_nxt;
          k                       <= last_slice ? '0 : k + 1'b1;
`ifdef CLA_OVERFLOW_EN
          if (last_slice) ovf_q <= msb_cin ^ carry_nxt;
`endif
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;

endmodule
